// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round sequencer and compression core.
package sha256_pkg;

    localparam int unsigned ROUNDS  = 64;
    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned CNT_W   = $clog2(ROUNDS);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRound,
        StUpdate,
        StDone
    } state_e;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // K-ROM lookup addressed by the sequencer's round index.
    function automatic logic [31:0] k_word(input logic [CNT_W-1:0] idx);
        return K[idx];
    endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round counter with clear, enable and terminal-count flag; wraps (or holds) at ROUNDS-1.
module sha256_round_cnt
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS   = sha256_pkg::ROUNDS,
    parameter int unsigned CNT_W    = $clog2(ROUNDS),
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc  = (cnt_q == LAST);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (tc) begin
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Block sequencer for one SHA-256 compression engine: buffer a block, load the schedule,
// step 64 rounds, accumulate H and present the digest at the end of a message.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS  = sha256_pkg::ROUNDS,
    parameter int unsigned BLOCK_W = sha256_pkg::BLOCK_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [BLOCK_W-1:0]        blk_data,
    input  logic                      blk_first,
    input  logic                      blk_last,
    output logic [BLOCK_W-1:0]        sched_block,
    output logic                      sched_load,
    output logic                      core_init,
    output logic                      core_init_iv,
    output logic                      round_en,
    output logic [$clog2(ROUNDS)-1:0] round_idx,
    output logic                      hash_update,
    output logic                      digest_valid,
    input  logic                      digest_ready,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(ROUNDS);

    state_e             state_q;
    logic [BLOCK_W-1:0] block_q;
    logic               first_q;
    logic               last_q;
    logic               sched_load_q;
    logic               core_init_q;
    logic               round_en_q;
    logic               hash_update_q;
    logic               digest_valid_q;

    logic               accept;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
    logic [CNT_W-1:0]   cnt;

    // Ready depends only on registered state, never on blk_valid.
    assign blk_ready = (state_q == StIdle);
    assign accept    = blk_valid & blk_ready;
    assign busy      = (state_q != StIdle);

    // Counter sits at 0 outside ROUND so the first round always addresses K[0].
    assign cnt_clr = (state_q != StRound);
    assign cnt_en  = (state_q == StRound);

    sha256_round_cnt #(
        .ROUNDS   (ROUNDS),
        .CNT_W    (CNT_W),
        .SATURATE (1'b0)
    ) u_round_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            block_q        <= '0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            sched_load_q   <= 1'b0;
            core_init_q    <= 1'b0;
            round_en_q     <= 1'b0;
            hash_update_q  <= 1'b0;
            digest_valid_q <= 1'b0;
        end else begin
            sched_load_q  <= 1'b0;
            core_init_q   <= 1'b0;
            hash_update_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        block_q      <= blk_data;
                        first_q      <= blk_first;
                        last_q       <= blk_last;
                        sched_load_q <= 1'b1;
                        core_init_q  <= 1'b1;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    round_en_q <= 1'b1;
                    state_q    <= StRound;
                end
                StRound: begin
                    if (cnt_tc) begin
                        round_en_q    <= 1'b0;
                        hash_update_q <= 1'b1;
                        state_q       <= StUpdate;
                    end
                end
                StUpdate: begin
                    if (last_q) begin
                        digest_valid_q <= 1'b1;
                        state_q        <= StDone;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StDone: begin
                    if (digest_ready) begin
                        digest_valid_q <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sched_block  = block_q;
    assign sched_load   = sched_load_q;
    assign core_init    = core_init_q;
    // A first block restarts from IV even if the previous message never saw its last block.
    assign core_init_iv = core_init_q & first_q;
    assign round_en     = round_en_q;
    assign round_idx    = cnt;
    assign hash_update  = hash_update_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencer for one SHA-256 compression engine. Accepts 512-bit message blocks over a valid/ready handshake and buffers each one. It loads the message-schedule shift register and drives the 64-round counter, round enable and K-ROM index. It then triggers the H-register accumulate and presents digest-valid at the end of the last block of a message.

Parameters:
ROUNDS, 64, rounds per block; round counter width is $clog2(ROUNDS)
BLOCK_W, 512, block width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
blk_valid  in  1  upstream block available
blk_ready  out  1  controller can accept a block
blk_data  in  BLOCK_W  message block, word 0 in MSBs
blk_first  in  1  block is the first of a message (H from IV)
blk_last  in  1  block is the last of a message
sched_block  out  BLOCK_W  buffered block, drives schedule load data
sched_load  out  1  schedule register load strobe (schedule's reset/load input)
core_init  out  1  load working vars a..h from H (or IV)
core_init_iv  out  1  with core_init: use IV instead of H
round_en  out  1  compression round step this cycle
round_idx  out  $clog2(ROUNDS)  current round t, K-ROM address
hash_update  out  1  H += working vars this cycle
digest_valid  out  1  H holds final digest
digest_ready  in  1  downstream consumed digest
busy  out  1  not IDLE

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- States: IDLE, LOAD, ROUND, UPDATE, DONE.
- Reset:
  - state = IDLE; round_idx = 0.
  - All strobes, digest_valid and busy = 0; blk_ready = 1 in the cycle after reset deasserts.
  - sched_block, first_q and last_q are cleared to 0.
- Reset mid-operation aborts the block. No hash_update or digest_valid is issued for it.
- IDLE:
  - blk_ready = 1.
  - On blk_valid & blk_ready: capture blk_data into sched_block, and blk_first/blk_last into first_q/last_q. Next state is LOAD.
  - blk_ready is never combinationally dependent on blk_valid.
- LOAD (1 cycle): sched_load = 1, core_init = 1, core_init_iv = first_q. Next state is ROUND with round_idx = 0.
- ROUND:
  - round_en = 1 every cycle; round_idx increments 0..ROUNDS-1.
  - The schedule word w_t presented during cycle t equals W[t], because the schedule register shifts once per cycle after the load.
  - At round_idx == ROUNDS-1 the next state is UPDATE, and round_idx wraps to 0.
  - sched_load stays 0 throughout, so the schedule keeps shifting.
- UPDATE (1 cycle): hash_update = 1. Next state is DONE if last_q, else IDLE.
- DONE:
  - digest_valid = 1 and held stable until digest_ready is sampled high; then next state is IDLE.
  - digest_ready while not DONE is ignored.
- Latency: accept edge to first round_en cycle = 2 cycles; accept to hash_update = ROUNDS+2 cycles; to digest_valid = ROUNDS+3 cycles (67 at default).
- Back-to-back blocks: the next block is accepted only in IDLE. Minimum block period is ROUNDS+3 cycles (multi-block) or ROUNDS+4 cycles plus the digest wait (last block).
- blk_first with a message in progress (previous last not seen): the current message is silently abandoned and the new block starts from IV.
- blk_first & blk_last both set: single-block message, uses IV and ends in DONE.
- Mutual exclusion: at most one of sched_load, round_en, hash_update is high in any cycle.
- busy = (state != IDLE).

Decomposition:
- Package sha256_pkg:
  - state enum type;
  - ROUNDS and BLOCK_W constants;
  - IV constant array H0..H7;
  - K[0:63] round-constant array, indexed by round_idx in the compression core.
- One sub-module, sha256_round_cnt: a saturating/wrapping round counter with clear, enable and terminal-count flag. Everything else stays flat in the FSM module.

Test Plan:
- Single-block "abc" (blk_data = 0x61626380_0..0_00000018, first = last = 1):
  - accept at cycle 0, sched_load at cycle 1;
  - round_en cycles 2..65 with round_idx 0..63;
  - with the schedule register attached, w_t = 0x61626380 at t=0, 0x61626380 at t=16, 0x000F0000 at t=17;
  - hash_update at cycle 66, digest_valid from cycle 67.
- Two-block message (first=1,last=0 then first=0,last=1):
  - block 1: core_init_iv = 1 and no digest_valid after hash_update;
  - block 2: core_init_iv = 0, accepted at the earliest at cycle 67, digest_valid 67 cycles after its accept.
- Digest backpressure: hold digest_ready = 0 for 10 cycles. Required: digest_valid stays high, blk_ready = 0, no new accept; IDLE follows one cycle after digest_ready = 1.
- Reset asserted at round_idx = 30:
  - next cycle all strobes = 0, round_idx = 0, blk_ready = 1;
  - no hash_update and no digest_valid for the aborted block.
- blk_valid held high continuously with 3 queued blocks: exactly one accept per IDLE visit. Required: blk_ready never high outside IDLE, and sched_load/round_en/hash_update are never simultaneously high.
